// File: rtl/pong_pkg.sv
// Shared definitions for the pong paddle controllers: paddle FSM state
// encoding and default screen / bat geometry.
package pong_pkg;

  typedef enum logic [1:0] {
    PADDLE_IDLE = 2'd0,
    PADDLE_SLOW = 2'd1,
    PADDLE_FAST = 2'd2
  } paddle_state_t;

  localparam int DEF_SCREEN_H  = 480;
  localparam int DEF_BAT_SMALL = 40;
  localparam int DEF_BAT_LARGE = 80;

endpackage

// File: rtl/paddle_channel.sv
// One paddle: direction FSM with hold-to-accelerate, hold counter, edge
// clamp and the registered top-edge Y. Priority per cycle is recenter,
// then bat-size correction, then tick movement.
module paddle_channel
  import pong_pkg::*;
#(
  parameter int Y_W        = 11,
  parameter int SCREEN_H   = DEF_SCREEN_H,
  parameter int BAT_SMALL  = DEF_BAT_SMALL,
  parameter int BAT_LARGE  = DEF_BAT_LARGE,
  parameter int HOLD_TICKS = 8,
  parameter int FAST_STEP  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           req_up,
  input  logic           req_dn,
  input  logic           bat_size,
  input  logic           bat_chg,
  input  logic           recenter,
  output logic [Y_W-1:0] y,
  output paddle_state_t  state_dbg
);

  localparam int YE = Y_W + 1;
  localparam int HW = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam logic [Y_W:0]  SCR   = YE'(SCREEN_H);
  localparam logic [Y_W:0]  BSM   = YE'(BAT_SMALL);
  localparam logic [Y_W:0]  BLG   = YE'(BAT_LARGE);
  localparam logic [Y_W:0]  FSTEP = YE'(FAST_STEP);
  localparam logic [Y_W:0]  RST_Y = YE'((SCREEN_H - BAT_SMALL) / 2);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS);

  paddle_state_t state, state_n;
  logic [HW-1:0] hold, hold_n;
  logic          dir, dir_n;       // 1 = moving down
  logic [Y_W:0]  y_r, y_n;         // one spare bit so arithmetic never wraps
  logic [Y_W:0]  bat_h, ymax, center, step, up_val, dn_sum, dn_val, move_val;
  logic          req_any;

  assign y         = y_r[Y_W-1:0];
  assign state_dbg = state;

  // State, hold counter, direction and Y register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= PADDLE_IDLE;
      hold  <= '0;
      dir   <= 1'b0;
      y_r   <= RST_Y;
    end else begin
      state <= state_n;
      hold  <= hold_n;
      dir   <= dir_n;
      y_r   <= y_n;
    end
  end

  // Geometry, clamped candidate moves, and next-state selection.
  always_comb begin
    bat_h    = bat_size ? BLG : BSM;
    ymax     = SCR - bat_h;
    center   = ymax >> 1;
    step     = (state == PADDLE_FAST) ? FSTEP : YE'(1);
    up_val   = (y_r < step) ? '0 : y_r - step;
    dn_sum   = y_r + step;
    dn_val   = (dn_sum > ymax) ? ymax : dn_sum;
    move_val = req_dn ? dn_val : up_val;
    req_any  = req_up | req_dn;

    state_n = state;
    hold_n  = hold;
    dir_n   = dir;
    y_n     = y_r;

    if (recenter) begin
      y_n     = center;
      state_n = PADDLE_IDLE;
      hold_n  = '0;
    end else if (bat_chg && (y_r > ymax)) begin
      y_n = ymax;
    end else if (tick) begin
      case (state)
        PADDLE_IDLE: begin
          if (req_any) begin
            state_n = (HOLD_LAST == HW'(1)) ? PADDLE_FAST : PADDLE_SLOW;
            dir_n   = req_dn;
            hold_n  = HW'(1);
            y_n     = move_val;
          end
        end
        PADDLE_SLOW, PADDLE_FAST: begin
          if (req_any && (req_dn == dir)) begin
            y_n = move_val;
            if (state == PADDLE_SLOW) begin
              hold_n = hold + HW'(1);
              if (hold + HW'(1) == HOLD_LAST) state_n = PADDLE_FAST;
            end
          end else begin
            // Release or reversal: spend this tick idle.
            state_n = PADDLE_IDLE;
            hold_n  = '0;
          end
        end
        default: begin
          state_n = PADDLE_IDLE;
          hold_n  = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/paddle_ctrl_multi.sv
// N-player paddle controller: shared movement tick, button synchronisers
// (plus a 2^16-cycle debouncer when PADDLE_DEBOUNCE_EN is defined),
// bat-size change detection and one paddle_channel per player.
module paddle_ctrl_multi
  import pong_pkg::*;
#(
  parameter int N_PLAYERS  = 2,
  parameter int Y_W        = 11,
  parameter int SCREEN_H   = DEF_SCREEN_H,
  parameter int BAT_SMALL  = DEF_BAT_SMALL,
  parameter int BAT_LARGE  = DEF_BAT_LARGE,
  parameter int TICK_DIV   = 250000,
  parameter int HOLD_TICKS = 8,
  parameter int FAST_STEP  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_PLAYERS-1:0]     up,
  input  logic [N_PLAYERS-1:0]     dn,
  input  logic                     bat_size,
  input  logic                     recenter,
  output logic [N_PLAYERS*Y_W-1:0] paddle_y,
  output logic [N_PLAYERS-1:0]     moving
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int NB = 2 * N_PLAYERS;

  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [NB-1:0] btn_s1, btn_s2, btn_f;
  logic          bat_q;
  logic          bat_chg;
  logic [N_PLAYERS-1:0] req_up, req_dn;
  paddle_state_t st [N_PLAYERS];

  assign tick    = (tick_cnt == CW'(TICK_DIV - 1));
  assign bat_chg = bat_size ^ bat_q;

  // Free-running movement tick counter shared by all players.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + CW'(1);
  end

  // Two-flop button synchroniser and previous bat_size.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      bat_q  <= 1'b0;
    end else begin
      btn_s1 <= {dn, up};
      btn_s2 <= btn_s1;
      bat_q  <= bat_size;
    end
  end

`ifdef PADDLE_DEBOUNCE_EN
  logic [NB-1:0] btn_db;
  logic [15:0]   db_cnt [NB];

  // Per-button debouncer: output follows only after 2^16 stable cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_db <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (btn_s2[i] == btn_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == 16'hFFFF) begin
          btn_db[i] <= btn_s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
    end
  end

  assign btn_f = btn_db;
`else
  assign btn_f = btn_s2;
`endif

  // Pressing both buttons of a player cancels the request.
  assign req_up = btn_f[N_PLAYERS-1:0] & ~btn_f[NB-1:N_PLAYERS];
  assign req_dn = btn_f[NB-1:N_PLAYERS] & ~btn_f[N_PLAYERS-1:0];

  for (genvar i = 0; i < N_PLAYERS; i++) begin : g_ch
    paddle_channel #(
      .Y_W       (Y_W),
      .SCREEN_H  (SCREEN_H),
      .BAT_SMALL (BAT_SMALL),
      .BAT_LARGE (BAT_LARGE),
      .HOLD_TICKS(HOLD_TICKS),
      .FAST_STEP (FAST_STEP)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .req_up   (req_up[i]),
      .req_dn   (req_dn[i]),
      .bat_size (bat_size),
      .bat_chg  (bat_chg),
      .recenter (recenter),
      .y        (paddle_y[i*Y_W +: Y_W]),
      .state_dbg(st[i])
    );
    assign moving[i] = (st[i] != PADDLE_IDLE);
  end

endmodule

// File: tb/tb_paddle_ctrl_multi.sv
// Bench for paddle_ctrl_multi with a short tick (TICK_DIV=4, HOLD_TICKS=3).
// Expected Y pairs are queued as buttons are driven and popped after each
// tick.
module tb_paddle_ctrl_multi;

  localparam int N  = 2;
  localparam int YW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  up, dn;
  logic          bat_size, recenter;
  logic [N*YW-1:0] paddle_y;
  logic [N-1:0]  moving;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [YW-1:0] exp_q[$];

  paddle_ctrl_multi #(
    .N_PLAYERS (N),
    .Y_W       (YW),
    .TICK_DIV  (4),
    .HOLD_TICKS(3),
    .FAST_STEP (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .up      (up),
    .dn      (dn),
    .bat_size(bat_size),
    .recenter(recenter),
    .paddle_y(paddle_y),
    .moving  (moving)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Safety net against a stuck run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int y_of(input int i);
    return int'(paddle_y[i*YW +: YW]);
  endfunction

  task automatic push2(input int a, input int b);
    exp_q.push_back(YW'(a));
    exp_q.push_back(YW'(b));
  endtask

  // Wait for the next movement tick edge; return #1 after it.
  task automatic wait_tick();
    int n;
    n = 0;
    @(negedge clk);
    while (dut.tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("tick_timeout", n, 0);
    @(posedge clk);
    #1;
  endtask

  // Let one tick happen and compare both paddles against the queue.
  task automatic tick_check(input string tag);
    logic [YW-1:0] e;
    wait_tick();
    for (int i = 0; i < N; i++) begin
      if (exp_q.size() == 0) begin
        check({tag, "_queue"}, 0, 1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s_y%0d", tag, i), y_of(i), int'(e));
      end
    end
  endtask

  initial begin
    int e0, e1, st;
    rst = 1'b0; up = '0; dn = '0; bat_size = 1'b0; recenter = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_y0", y_of(0), 220);
    check("rst_y1", y_of(1), 220);
    check("rst_moving", int'(moving), 0);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_y0", y_of(0), 220);
    check("idle_y1", y_of(1), 220);
    check("idle_moving", int'(moving), 0);
    wait_tick();

    // P0 down: three slow steps then fast.
    dn = 2'b01;
    push2(221, 220); push2(222, 220); push2(223, 220);
    push2(227, 220); push2(231, 220);
    repeat (5) tick_check("p0_dn");
    check("p0_dn_moving", int'(moving), 1);
    dn = 2'b00;
    push2(231, 220);
    tick_check("p0_release");
    check("p0_release_moving", int'(moving), 0);

    // P0 down to the bottom, P1 up to the top, both clamp.
    dn = 2'b01; up = 2'b10;
    e0 = 231; e1 = 220;
    for (int k = 0; k < 64; k++) begin
      st = (k < 3) ? 1 : 4;
      e0 = (e0 + st > 440) ? 440 : e0 + st;
      e1 = (e1 < st) ? 0 : e1 - st;
      push2(e0, e1);
    end
    repeat (64) tick_check("ramp");
    check("ramp_moving", int'(moving), 3);
    dn = 2'b00; up = 2'b00;
    push2(440, 0);
    tick_check("ramp_release");
    check("ramp_release_moving", int'(moving), 0);

    // Large bat pulls P0 back to the new bottom without a tick.
    bat_size = 1'b1;
    @(posedge clk); #1;
    check("bat_y0", y_of(0), 400);
    check("bat_y1", y_of(1), 0);
    wait_tick();

    // Both buttons on P0: no movement.
    up = 2'b01; dn = 2'b01;
    for (int k = 0; k < 4; k++) begin
      push2(400, 0);
      tick_check("both");
      check("both_moving", int'(moving), 0);
    end

    // P0 up into FAST, then reversal costs one idle tick.
    dn = 2'b00; up = 2'b01;
    push2(399, 0); push2(398, 0); push2(397, 0); push2(393, 0); push2(389, 0);
    repeat (5) tick_check("p0_up");
    up = 2'b00; dn = 2'b01;
    push2(389, 0);
    tick_check("rev_idle");
    check("rev_idle_moving", int'(moving[0]), 0);
    push2(390, 0);
    tick_check("rev_slow");
    check("rev_slow_moving", int'(moving[0]), 1);

    // Both players into FAST, then recenter with the large bat.
    up = 2'b10;
    push2(391, 0); push2(392, 0); push2(396, 0); push2(400, 0);
    repeat (4) tick_check("fast_both");
    check("fast_both_moving", int'(moving), 3);
    recenter = 1'b1;
    @(posedge clk); #1;
    recenter = 1'b0;
    check("rc_y0", y_of(0), 200);
    check("rc_y1", y_of(1), 200);
    check("rc_moving", int'(moving), 0);
    push2(201, 199);
    tick_check("after_rc");
    check("after_rc_moving", int'(moving), 3);

    // Asynchronous reset mid-operation.
    #3;
    rst = 1'b0;
    #1;
    check("arst_y0", y_of(0), 220);
    check("arst_y1", y_of(1), 220);
    check("arst_moving", int'(moving), 0);
    check("queue_drained", exp_q.size(), 0);
    up = '0; dn = '0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/paddle_ctrl_multi.md
Name: paddle_ctrl_multi

Overview:
- Parametrised successor to the two-player button paddle controller.
- Drives N independent paddles from up/down buttons, with hold-to-accelerate motion, two bat sizes and screen-edge clamping.
- Global recenter command included.
- Sits between the button inputs and game_controller/video_encoder; outputs each paddle's top-edge Y in screen pixels.

Parameters:
- N_PLAYERS, 2, number of paddles/channels (1..4).
- Y_W, 11, width of each paddle Y coordinate.
- SCREEN_H, 480, visible line count.
- BAT_SMALL, 40, paddle height when bat_size=0.
- BAT_LARGE, 80, paddle height when bat_size=1.
- TICK_DIV, 250000, clk cycles per movement tick (>=2).
- HOLD_TICKS, 8, ticks held in SLOW before entering FAST.
- FAST_STEP, 4, pixels per tick in FAST (SLOW moves 1 px/tick).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- up  in  N_PLAYERS  per-player move-up button, active-high (decreases Y)
- dn  in  N_PLAYERS  per-player move-down button, active-high (increases Y)
- bat_size  in  1  0=BAT_SMALL, 1=BAT_LARGE, shared by all paddles
- recenter  in  1  single-cycle pulse: all paddles to centre
- paddle_y  out  N_PLAYERS*Y_W  player i at bits [i*Y_W +: Y_W], top edge
- moving  out  N_PLAYERS  1 while player i is in SLOW or FAST

Behaviour:
- Reset (rst=0, async):
  - tick counter = 0
  - every paddle_y = (SCREEN_H-BAT_SMALL)/2 = 220 at defaults
  - every FSM = IDLE, hold counter = 0, moving = 0
- Tick generator:
  - Counter runs 0..TICK_DIV-1; tick is asserted for one cycle when the count equals TICK_DIV-1, then the counter wraps to 0.
  - Shared by all players.
- bat_h = bat_size ? BAT_LARGE : BAT_SMALL.
- ymax = SCREEN_H - bat_h; all arithmetic is Y_W+1 bits to avoid underflow.
- Per-player direction: dir_up = up & ~dn; dir_dn = dn & ~up. Both or neither = no request.
- Per-player FSM (advances only on tick, except recenter):
  - IDLE: request present -> SLOW, move 1 px this tick, hold = 1.
  - SLOW: request same direction -> move 1 px, hold+1; when hold reaches HOLD_TICKS -> FAST.
  - FAST: request same direction -> move FAST_STEP px.
  - SLOW/FAST, any state: request absent or direction reversed -> IDLE, hold = 0, no move this tick. A reversal therefore costs one idle tick.
- Clamping:
  - Up move: y_new = (y < step) ? 0 : y - step.
  - Down move: y_new = (y + step > ymax) ? ymax : y + step.
  - Reaching a bound does not change FSM state.
- bat_size change: on the cycle after bat_size changes, any paddle with y > ymax is forced to ymax, independent of tick. This correction has priority over tick movement in that cycle.
- recenter:
  - Highest priority; takes effect the cycle after the pulse.
  - All y = (SCREEN_H - bat_h)/2 using the current bat_size.
  - All FSMs = IDLE, hold = 0.
  - Tick counter is unaffected.
- Output timing: paddle_y and moving are registered; they update one cycle after the tick or event.
- Players are fully independent; simultaneous ticks for all players are the normal case.

Optional Feature:
- PADDLE_DEBOUNCE_EN defined:
  - Each up/dn bit passes through a 2-flop synchroniser and a debouncer.
  - The debouncer changes its output only after the synchronised input has been stable for 2^16 clk cycles.
  - Button-to-FSM latency is +2 cycles plus the stable window.
- Undefined: up/dn go only through the 2-flop synchroniser (latency +2 cycles). External debouncers are the caller's responsibility.

Decomposition:
- Shared package (pong_pkg):
  - State encoding constants PADDLE_IDLE / PADDLE_SLOW / PADDLE_FAST.
  - Default SCREEN_H, BAT_SMALL, BAT_LARGE.
- One natural sub-module: paddle_channel. It contains the FSM, hold counter, clamp and Y register, and is instantiated N_PLAYERS times via generate.
- The tick generator and the optional debouncer stay in the parent.

Test Plan (TICK_DIV=4, HOLD_TICKS=3, FAST_STEP=4, defaults otherwise):
- Reset release -> all paddle_y = 220, moving = 0; no change with no buttons for 100 cycles.
- P0 dn held 5 ticks -> y steps 221, 222, 223 (SLOW), then 227, 231 (FAST); P1 stays at 220.
- P1 up held from y=2 -> y 1, 0, 0, 0; moving stays 1 throughout. P0 dn held to the bottom with bat_size=0 -> y saturates at 440.
- P0 at y=430, bat_size 0→1 -> the next cycle y = 400 with no tick required.
- P0 up and dn together for 4 ticks -> y unchanged, moving = 0. Direction reversal from FAST -> one tick with no move, then SLOW in the new direction.
- recenter pulse while both players are in FAST with bat_size=1 -> both y = 200, moving = 0 the next cycle. A mid-operation rst=0 then forces y = 220 immediately.
